// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiply, restoring divide, one bit/cycle.
// Optional multiply datapath enabled by defining MULDIV_MUL_EN; otherwise MUL* ops return 0.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(XLEN);
`ifdef MULDIV_MUL_EN
    localparam int unsigned AccW = 2 * XLEN;
`else
    localparam int unsigned AccW = XLEN;
`endif
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            sel_rem_q;
    logic            neg_a_q, neg_b_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] rem_q;
    logic [AccW-1:0] acc_q;
    logic [XLEN-1:0] result_q;
`ifdef MULDIV_MUL_EN
    logic            sel_div_q, sel_lo_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN:0]   mul_sum;
    logic [AccW-1:0] prod;
`endif

    logic            is_div, a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_by_zero, overflow, fast;
    logic [XLEN-1:0] fast_result;
    logic [AccW-1:0] acc_init, acc_step;
    logic [XLEN:0]   div_shift, div_trial;
    logic [XLEN-1:0] rem_step, quo, div_res, fix_result;

    // Operand decode at accept time
    always_comb begin
        is_div      = funct3[2];
        a_signed    = is_div ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        b_signed    = is_div ? !funct3[0] : (funct3[1:0] == 2'b01);
        sa          = a_signed & op_a[XLEN-1];
        sb          = b_signed & op_b[XLEN-1];
        abs_a       = sa ? -op_a : op_a;
        abs_b       = sb ? -op_b : op_b;
        div_by_zero = is_div && (op_b == '0);
        overflow    = is_div && !funct3[0] && (op_a == MinInt) && (op_b == '1);
`ifdef MULDIV_MUL_EN
        fast        = div_by_zero | overflow;
        acc_init    = is_div ? AccW'(abs_a) : AccW'(abs_b);
`else
        fast        = !is_div | div_by_zero | overflow;
        acc_init    = AccW'(abs_a);
`endif
        fast_result = '0;
        if (div_by_zero) begin
            fast_result = funct3[1] ? op_a : '1;
        end else if (overflow) begin
            fast_result = funct3[1] ? '0 : MinInt;
        end
    end

    // One iteration: quotient bits shift into acc_q low half; product accumulates in acc_q
    always_comb begin
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_trial = div_shift - {1'b0, b_q};
        rem_step  = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
        acc_step  = acc_q;
        acc_step[XLEN-1:0] = {acc_q[XLEN-2:0], ~div_trial[XLEN]};
`ifdef MULDIV_MUL_EN
        mul_sum = {1'b0, acc_q[AccW-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        if (!sel_div_q) begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
`endif
    end

    always_comb begin
        quo        = acc_q[XLEN-1:0];
        div_res    = sel_rem_q ? (neg_a_q ? -rem_q : rem_q)
                               : ((neg_a_q ^ neg_b_q) ? -quo : quo);
        fix_result = div_res;
`ifdef MULDIV_MUL_EN
        prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        if (!sel_div_q) begin
            fix_result = sel_lo_q ? prod[XLEN-1:0] : prod[AccW-1:XLEN];
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = fast ? StDone : StCalc;
            StCalc:  if (cnt_q == '0) state_d = StFixup;
            StFixup: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            sel_rem_q <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            b_q       <= '0;
            rem_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
`ifdef MULDIV_MUL_EN
            sel_div_q <= 1'b0;
            sel_lo_q  <= 1'b0;
            a_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt_q     <= CntW'(XLEN - 1);
                        sel_rem_q <= funct3[1];
                        neg_a_q   <= sa;
                        neg_b_q   <= sb;
                        b_q       <= abs_b;
                        rem_q     <= '0;
                        acc_q     <= acc_init;
`ifdef MULDIV_MUL_EN
                        sel_div_q <= is_div;
                        sel_lo_q  <= (funct3[1:0] == 2'b00);
                        a_q       <= abs_a;
`endif
                        if (fast) result_q <= fast_result;
                    end
                end
                StCalc: begin
                    cnt_q <= cnt_q - 1'b1;
                    rem_q <= rem_step;
                    acc_q <= acc_step;
                end
                StFixup: result_q <= fix_result;
                default: ;
            endcase
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus re-pulse, DONE-cycle start and reset sequences.
module tb_muldiv_sequencer;

    localparam int Slow = 34;
`ifdef MULDIV_MUL_EN
    localparam int MulLat = 34;
    localparam bit MulOn  = 1'b1;
`else
    localparam int MulLat = 1;
    localparam bit MulOn  = 1'b0;
`endif
    localparam int NV = 26;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[NV];

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mexp(input logic [31:0] v);
        return MulOn ? v : 32'd0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Accept one op, scramble inputs afterwards, wait (bounded) for done
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit busy_ok);
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
        lat = 1; busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        res = result;
    endtask

    initial begin
        logic [31:0] res;
        int lat;
        bit bok;
        bit seen_done;

        vecs[0]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, Slow};
        vecs[1]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, Slow};
        vecs[2]  = '{3'b111, 32'd100,       32'd7,         32'd2,         Slow};
        vecs[3]  = '{3'b101, 32'd100,       32'd7,         32'd14,        Slow};
        vecs[4]  = '{3'b101, 32'd100,       32'd0,         32'hFFFF_FFFF, 1};
        vecs[5]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[6]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[7]  = '{3'b111, 32'd5,         32'd0,         32'd5,         1};
        vecs[8]  = '{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1};
        vecs[9]  = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, Slow};
        vecs[10] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         Slow};
        vecs[11] = '{3'b100, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'd3,         Slow};
        vecs[12] = '{3'b110, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'hFFFF_FFFE, Slow};
        vecs[13] = '{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, Slow};
        vecs[14] = '{3'b111, 32'hFFFF_FFFF, 32'h10,        32'hF,         Slow};
        vecs[15] = '{3'b100, 32'h8000_0000, 32'd2,         32'hC000_0000, Slow};
        vecs[16] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         Slow};
        vecs[17] = '{3'b100, 32'd123,       32'd0,         32'hFFFF_FFFF, 1};
        vecs[18] = '{3'b001, 32'h8000_0000, 32'h8000_0000, mexp(32'h4000_0000), MulLat};
        vecs[19] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mexp(32'hFFFF_FFFF), MulLat};
        vecs[20] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mexp(32'd1),         MulLat};
        vecs[21] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mexp(32'hFFFF_FFFE), MulLat};
        vecs[22] = '{3'b000, 32'd3,         32'hFFFF_FFFB, mexp(32'hFFFF_FFF1), MulLat};
        vecs[23] = '{3'b001, 32'd3,         32'hFFFF_FFFB, mexp(32'hFFFF_FFFF), MulLat};
        vecs[24] = '{3'b011, 32'd3,         32'hFFFF_FFFB, mexp(32'd2),         MulLat};
        vecs[25] = '{3'b010, 32'hFFFF_FFFB, 32'd3,         mexp(32'hFFFF_FFFF), MulLat};

        rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset busy",   {31'd0, busy}, 32'd0);
        check("reset done",   {31'd0, done}, 32'd0);
        check("reset result", result,        32'd0);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, bok);
            check($sformatf("vec%0d f=%b result", i, vecs[i].f), res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d busy held", i), {31'd0, bok}, 32'd1);
            @(posedge clk); #1;
            check($sformatf("vec%0d done pulse width", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d busy after done", i), {31'd0, busy}, 32'd0);
            check($sformatf("vec%0d result held", i), result, vecs[i].exp);
        end

        // start re-pulsed at T+5 with new operands must be ignored
        @(negedge clk);
        funct3 = 3'b100; op_a = 32'hFFFF_FFF9; op_b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (lat == 5) begin
                start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("repulse result",  result,    32'hFFFF_FFFD);
        check("repulse latency", 32'(lat),  32'(Slow));

        // start during the DONE cycle is ignored
        start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("done-cycle start busy",   {31'd0, busy}, 32'd0);
        check("done-cycle start done",   {31'd0, done}, 32'd0);
        check("done-cycle start result", result,        32'hFFFF_FFFD);
        @(posedge clk); #1;
        check("done-cycle start no late done", {31'd0, done}, 32'd0);

        // reset mid-operation at T+10
        @(negedge clk);
        funct3 = 3'b100; op_a = 32'hFFFF_FFF9; op_b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid-rst busy",   {31'd0, busy}, 32'd0);
        check("mid-rst done",   {31'd0, done}, 32'd0);
        check("mid-rst result", result,        32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("mid-rst no done afterwards", {31'd0, seen_done}, 32'd0);
        run_op(3'b101, 32'd100, 32'd7, res, lat, bok);
        check("post-rst DIVU result",  res,      32'd14);
        check("post-rst DIVU latency", 32'(lat), 32'(Slow));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
